vector_chunk_engine: RTL and testbench
======================================

# vector_chunk_engine

Parametrised, multi-cycle successor to the single-cycle `vector` unit. It processes a `W`-bit operand pair in `CHUNK_W`-bit slices, one slice per cycle, using valid/ready handshakes on both sides. It supports full-width big-integer add/sub with carry/borrow propagated across slices, plus two lane-wise modes. It sits between the operand buffers and the result writeback in the vector datapath.

## Interface
Parameters:
- `W`, 3072: total operand width in bits.
- `CHUNK_W`, 256: bits processed per cycle. `W % CHUNK_W == 0` is required, else elaboration error.
- `LANE_W`, 32: lane width for the lane-wise modes. `CHUNK_W % LANE_W == 0` is required, else elaboration error.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operands and mode present.
- `in_ready`  out  1  engine idle, can accept.
- `A`  in  W  operand A, unsigned.
- `B`  in  W  operand B, unsigned.
- `mod`  in  2  operation: 0 big add, 1 big sub (A−B), 2 lane XOR, 3 lane add mod 2^LANE_W.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out`  out  W  result.
- `carry_out`  out  1  final carry (mode 0), final borrow (mode 1), 0 otherwise.

## Operation
- FSM states IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: `in_ready`=1.
  - On `in_valid && in_ready`, latch A, B, mod.
  - Clear chunk index k and carry register.
  - Go to RUN.
- RUN: each cycle, compute chunk k (bits `k*CHUNK_W +: CHUNK_W`) from the latched operands, latched mode and carry register. Write it into the `out` register and update carry.
  - Mode 0: carry-in starts at 0. The carry out of chunk k feeds chunk k+1.
  - Mode 1: computed as A + ~B + 1. Carry-in starts at 1. Borrow = NOT final carry.
  - Modes 2/3: each lane is independent. No carry crosses lane or chunk boundaries. Carry register is held at 0.
  - When k = W/CHUNK_W−1: register `carry_out` and go to DONE.
- DONE: `out_valid`=1. `out` and `carry_out` are held stable until `out_valid && out_ready`, then return to IDLE.
- `mod`, `A`, `B` changes outside the accept cycle are ignored.
- `in_ready` is 0 in RUN and DONE. There is no overlap of operations.
- Reset values: `out`=0, `carry_out`=0, `out_valid`=0, `in_ready`=1, k=0.
- Reset mid-RUN or mid-DONE: immediate return to IDLE with the reset values above. The partial result is discarded.
- `out` bits of chunks not yet processed keep their previous value during RUN. Only DONE contents are architecturally defined.

## Timing
- Accept edge E0. Chunks are written at edges E1..EN, where N = W/CHUNK_W (12 by default). `out_valid` is high after EN, so latency = N cycles from accept.
- The earliest next accept is the edge after the `out_valid && out_ready` edge. Best-case throughput is one operation per N+2 cycles.
- The critical path is one CHUNK_W-bit adder plus the mode mux. There is no W-wide combinational carry chain.
- `in_ready` and `out_valid` are registered state decodes. Neither depends combinationally on `in_valid` or `out_ready`.

## Structure
- Shared package `vector_pkg`:
  - mode encoding constants (MODE_ADD=0, MODE_SUB=1, MODE_XOR=2, MODE_LADD=3);
  - FSM state encoding;
  - a function for N = W/CHUNK_W and the index width.
- Sub-module `vector_chunk_alu`: purely combinational.
  - Inputs: CHUNK_W-bit a and b, mode, carry_in.
  - Outputs: CHUNK_W-bit result, carry_out.
  - Parametrised by CHUNK_W and LANE_W.
- Top level holds the FSM, operand and result registers, chunk counter and carry register.

## Test plan
- A=0x0000ffff, B=0x0abcffff, mode 0 → after 12 cycles, out=0x0abdfffe, carry_out=0. Mode 2 on the same operands → out=0x0abc0000.
- Same operands, mode 1 → out upper W−32 bits all ones, low 32 bits=0xf5440000, carry_out=1. Mode 3 → lane0=0x0abdfffe, other lanes 0.
- A=2^256−1, B=1: mode 0 → out=2^256 (carry crosses chunk 0→1), carry_out=0. Mode 3 → low 32 bits 0x00000000, bits 255:32 still all ones, bits ≥256 zero.
- A=all ones, B=1, mode 0 → out=0, carry_out=1. A=0, B=0, mode 1 → out=0, carry_out=0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out`/`carry_out` stable, `in_ready`=0, a pending `in_valid` is not accepted. Release → the handshake completes and the new operation is accepted 1 cycle later.
- Assert `rst` at chunk k=5 → all outputs take their reset values asynchronously. After release, a new mode 0 operation completes correctly in 12 cycles.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared definitions for the chunked vector engine: mode and FSM encodings
// plus helpers that derive the chunk count and chunk-index width.
package vector_pkg;

  localparam logic [1:0] MODE_ADD  = 2'd0;
  localparam logic [1:0] MODE_SUB  = 2'd1;
  localparam logic [1:0] MODE_XOR  = 2'd2;
  localparam logic [1:0] MODE_LADD = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int num_chunks(input int w, input int cw);
    return w / cw;
  endfunction

  // A single-chunk configuration still gets a 1-bit index register.
  function automatic int idx_width(input int w, input int cw);
    int n;
    n = w / cw;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vector_chunk_alu.sv
// Combinational slice ALU: chunk-wide add/sub with carry in/out, or
// lane-wise XOR / modular add where nothing crosses a lane boundary.
module vector_chunk_alu
  import vector_pkg::*;
#(
  parameter int CHUNK_W = 256,
  parameter int LANE_W  = 32
) (
  input  logic [CHUNK_W-1:0] a_i,
  input  logic [CHUNK_W-1:0] b_i,
  input  logic [1:0]         mode_i,
  input  logic               carry_i,
  output logic [CHUNK_W-1:0] result_o,
  output logic               carry_o
);

  localparam int LANES = CHUNK_W / LANE_W;

  logic [CHUNK_W-1:0] b_eff_s;
  logic [CHUNK_W:0]   sum_s;
  logic [CHUNK_W-1:0] lane_sum_s;

  // Subtraction is A + ~B with the carry-in supplied by the caller.
  assign b_eff_s = (mode_i == MODE_SUB) ? ~b_i : b_i;
  assign sum_s   = {1'b0, a_i} + {1'b0, b_eff_s} + {{CHUNK_W{1'b0}}, carry_i};

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_sum_s[l*LANE_W +: LANE_W] = a_i[l*LANE_W +: LANE_W] + b_i[l*LANE_W +: LANE_W];
  end

  always_comb begin
    result_o = {CHUNK_W{1'b0}};
    carry_o  = 1'b0;
    case (mode_i)
      MODE_ADD, MODE_SUB: begin
        result_o = sum_s[CHUNK_W-1:0];
        carry_o  = sum_s[CHUNK_W];
      end
      MODE_XOR: begin
        result_o = a_i ^ b_i;
        carry_o  = 1'b0;
      end
      MODE_LADD: begin
        result_o = lane_sum_s;
        carry_o  = 1'b0;
      end
      default: begin
        result_o = {CHUNK_W{1'b0}};
        carry_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/vector_chunk_engine.sv
// Multi-cycle W-bit vector engine: latches an operand pair, processes one
// CHUNK_W slice per cycle and presents the result under valid/ready.
module vector_chunk_engine
  import vector_pkg::*;
#(
  parameter int W       = 3072,
  parameter int CHUNK_W = 256,
  parameter int LANE_W  = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [1:0]   mod,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         carry_out
);

  localparam int N     = num_chunks(W, CHUNK_W);
  localparam int IDX_W = idx_width(W, CHUNK_W);
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(N - 1);

  if (W % CHUNK_W != 0) begin : g_bad_chunk
    $error("vector_chunk_engine: W must be a multiple of CHUNK_W");
  end
  if (CHUNK_W % LANE_W != 0) begin : g_bad_lane
    $error("vector_chunk_engine: CHUNK_W must be a multiple of LANE_W");
  end

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [1:0]       mode_q, mode_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     out_q, out_d;
  logic             cout_q, cout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [CHUNK_W-1:0] alu_res_s;
  logic               alu_carry_s;
  logic               alu_cin_s;

  // The first chunk of a subtraction needs the +1 of the two's complement.
  assign alu_cin_s = (k_q == {IDX_W{1'b0}}) ? (mode_q == MODE_SUB) : carry_q;

  vector_chunk_alu #(
    .CHUNK_W (CHUNK_W),
    .LANE_W  (LANE_W)
  ) u_alu (
    .a_i      (a_q[k_q*CHUNK_W +: CHUNK_W]),
    .b_i      (b_q[k_q*CHUNK_W +: CHUNK_W]),
    .mode_i   (mode_q),
    .carry_i  (alu_cin_s),
    .result_o (alu_res_s),
    .carry_o  (alu_carry_s)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    k_d     = k_q;
    carry_d = carry_q;
    out_d   = out_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          mode_d  = mod;
          k_d     = {IDX_W{1'b0}};
          carry_d = 1'b0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        out_d[k_q*CHUNK_W +: CHUNK_W] = alu_res_s;
        carry_d = ((mode_q == MODE_ADD) || (mode_q == MODE_SUB)) ? alu_carry_s : 1'b0;
        if (k_q == LAST_K) begin
          case (mode_q)
            MODE_ADD: cout_d = alu_carry_s;
            MODE_SUB: cout_d = ~alu_carry_s;
            default:  cout_d = 1'b0;
          endcase
          k_d     = {IDX_W{1'b0}};
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // Handshake flags are registered decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      mode_q      <= MODE_ADD;
      k_q         <= {IDX_W{1'b0}};
      carry_q     <= 1'b0;
      out_q       <= {W{1'b0}};
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      k_q         <= k_d;
      carry_q     <= carry_d;
      out_q       <= out_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_vector_chunk_engine.sv
// Self-checking bench for vector_chunk_engine: directed and random operations
// compared against a whole-width arithmetic reference model.
module tb_vector_chunk_engine;

  localparam int W       = 3072;
  localparam int CHUNK_W = 256;
  localparam int LANE_W  = 32;
  localparam int N       = W / CHUNK_W;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [1:0]   mod;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dut_out;
  logic         carry_out;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [W-1:0] a_v, b_v, exp_out;
  logic         exp_c;

  vector_chunk_engine #(.W(W), .CHUNK_W(CHUNK_W), .LANE_W(LANE_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .mod       (mod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dut_out),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: full-width arithmetic, lanes handled independently.
  function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [1:0] m,
                                    output logic [W-1:0] r, output logic c);
    logic [W:0] t;
    r = '0;
    c = 1'b0;
    case (m)
      2'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[W-1:0]; c = t[W]; end
      2'd1: begin r = a - b; c = (a < b); end
      2'd2: begin r = a ^ b; c = 1'b0; end
      default: begin
        for (int l = 0; l < W / LANE_W; l++)
          r[l*LANE_W +: LANE_W] = a[l*LANE_W +: LANE_W] + b[l*LANE_W +: LANE_W];
        c = 1'b0;
      end
    endcase
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_vec(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    int c;
    c = 0;
    for (int i = N - 1; i >= 0; i--)
      if (got[i*CHUNK_W +: CHUNK_W] !== exp[i*CHUNK_W +: CHUNK_W]) c = i;
    cmp_cnt++;
    assert (got === exp) else begin
      err_cnt++;
      $error("FAIL %s chunk %0d: got %h expected %h", tag, c,
             got[c*CHUNK_W +: CHUNK_W], exp[c*CHUNK_W +: CHUNK_W]);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    cmp_cnt++;
    assert (got === exp) else begin
      err_cnt++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    cmp_cnt++;
    assert (got === exp) else begin
      err_cnt++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Leaves the bench at the falling edge right after the accept edge.
  task automatic start_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] m);
    @(negedge clk);
    check_bit({tag, " in_ready"}, in_ready, 1'b1);
    A = a; B = b; mod = m; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    A = rand_vec(); B = rand_vec(); mod = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [1:0] m);
    int j;
    j = 0;
    while (!out_valid && j < 40) begin
      @(negedge clk);
      j++;
    end
    ref_model(a, b, m, exp_out, exp_c);
    check_int({tag, " latency"}, j, N);
    check_vec({tag, " out"}, dut_out, exp_out);
    check_bit({tag, " carry_out"}, carry_out, exp_c);
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_bit({tag, " out_valid drop"}, out_valid, 1'b0);
    check_bit({tag, " in_ready back"}, in_ready, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] m);
    start_op(tag, a, b, m);
    wait_result(tag, a, b, m);
    finish_op(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; mod = 2'd0;
    #12;
    check_bit("reset in_ready", in_ready, 1'b1);
    check_bit("reset out_valid", out_valid, 1'b0);
    check_bit("reset carry_out", carry_out, 1'b0);
    check_vec("reset out", dut_out, '0);
    @(negedge clk);
    rst = 1'b0;

    a_v = '0; a_v[31:0] = 32'h0000ffff;
    b_v = '0; b_v[31:0] = 32'h0abcffff;
    run_op("small add", a_v, b_v, 2'd0);
    run_op("small xor", a_v, b_v, 2'd2);
    run_op("small sub", a_v, b_v, 2'd1);
    check_int("small sub low word", int'(dut_out[31:0]), int'(32'hf5440000));
    run_op("small ladd", a_v, b_v, 2'd3);

    a_v = '0; a_v[255:0] = {256{1'b1}};
    b_v = '0; b_v[0] = 1'b1;
    run_op("chunk carry add", a_v, b_v, 2'd0);
    run_op("chunk carry ladd", a_v, b_v, 2'd3);

    a_v = {W{1'b1}};
    run_op("wrap add", a_v, b_v, 2'd0);
    run_op("zero sub", '0, '0, 2'd1);

    // Backpressure with a second request already waiting.
    a_v = rand_vec(); b_v = rand_vec();
    start_op("bp first", a_v, b_v, 2'd0);
    wait_result("bp first", a_v, b_v, 2'd0);
    A = ~a_v; B = b_v; mod = 2'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_vec("bp hold out", dut_out, exp_out);
      check_bit("bp hold carry", carry_out, exp_c);
      check_bit("bp hold out_valid", out_valid, 1'b1);
      check_bit("bp hold in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_bit("bp release out_valid", out_valid, 1'b0);
    check_bit("bp release in_ready", in_ready, 1'b1);
    @(negedge clk);
    check_bit("bp second accepted", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_result("bp second", ~a_v, b_v, 2'd1);
    finish_op("bp second");

    // Asynchronous reset with chunk 5 in flight.
    a_v = rand_vec(); b_v = rand_vec();
    start_op("mid reset", a_v, b_v, 2'd0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_bit("mid reset in_ready", in_ready, 1'b1);
    check_bit("mid reset out_valid", out_valid, 1'b0);
    check_bit("mid reset carry_out", carry_out, 1'b0);
    check_vec("mid reset out", dut_out, '0);
    @(negedge clk);
    rst = 1'b0;
    a_v = rand_vec(); b_v = rand_vec();
    run_op("post reset add", a_v, b_v, 2'd0);

    for (int t = 0; t < 12; t++) begin
      logic [1:0] m;
      m   = 2'($urandom_range(0, 3));
      a_v = rand_vec();
      b_v = ($urandom_range(0, 3) == 0) ? ~a_v : rand_vec();
      run_op($sformatf("random %0d", t), a_v, b_v, m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
